// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit cache line transfers to four 64-bit memory bursts.
// Reads assemble beats into line_o; writes stream the latched line out beat by beat.
module cacheline_adaptor (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] line_i,
   output logic [255:0] line_o,
   input  logic [31:0]  address_i,
   input  logic         read_i,
   input  logic         write_i,
   output logic         resp_o,
   input  logic [63:0]  burst_i,
   output logic [63:0]  burst_o,
   output logic [31:0]  address_o,
   output logic         read_o,
   output logic         write_o,
   input  logic         resp_i
);

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRdDone,
      StWr,
      StWrDone
   } state_e;

   state_e         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [31:0]    addr_q, addr_d;
   logic [255:0]   wline_q, wline_d;
   logic [255:0]   rline_q, rline_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         addr_q  <= 32'd0;
         wline_q <= 256'd0;
         rline_q <= 256'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wline_q <= wline_d;
         rline_q <= rline_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wline_d = wline_q;
      rline_d = rline_q;
      unique case (state_q)
         StIdle: begin
            // Write wins over a simultaneous read.
            if (write_i) begin
               addr_d  = address_i;
               wline_d = line_i;
               cnt_d   = 2'd0;
               state_d = StWr;
            end else if (read_i) begin
               addr_d  = address_i;
               cnt_d   = 2'd0;
               state_d = StRd;
            end
         end
         StRd: begin
            if (resp_i) begin
               rline_d[{cnt_q, 6'd0} +: 64] = burst_i;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = StRdDone;
            end
         end
         StWr: begin
            if (resp_i) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = StWrDone;
            end
         end
         StRdDone: state_d = StIdle;
         StWrDone: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      read_o    = (state_q == StRd);
      write_o   = (state_q == StWr);
      resp_o    = (state_q == StRdDone) || (state_q == StWrDone);
      address_o = 32'd0;
      burst_o   = 64'd0;
      if (state_q == StRd || state_q == StWr) address_o = {addr_q[31:5], 5'd0};
      if (state_q == StWr) burst_o = wline_q[{cnt_q, 6'd0} +: 64];
   end

   assign line_o = rline_q;

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports named as follows.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have these line-side ports, which face the arbiter output.
- line_i  in  256  write line.
- line_o  out  256  read line.
- address_i  in  32  line address.
- read_i  in  1  line read request.
- write_i  in  1  line write request.
- resp_o  out  1  line transfer done.
REQ-003 SHALL have these burst-side ports, which face physical memory.
- burst_i  in  64  read beat.
- burst_o  out  64  write beat.
- address_o  out  32  burst address.
- read_o  out  1  burst read.
- write_o  out  1  burst write.
- resp_i  in  1  beat accepted/valid.

Function
REQ-004 SHALL implement the FSM states IDLE, RD, RD_DONE, WR and WR_DONE, with a 2-bit beat counter cnt.
REQ-005 In IDLE with write_i=1, SHALL latch address_i and line_i, clear cnt, and enter WR next cycle; write_i takes priority over a simultaneous read_i.
REQ-006 In IDLE with read_i=1 and write_i=0, SHALL latch address_i, clear cnt, and enter RD next cycle.
REQ-007 SHALL drive address_o = {latched address[31:5], 5'b0} in RD and WR, and SHALL ignore address_i outside IDLE.
REQ-008 In RD, SHALL drive read_o=1; on each cycle with resp_i=1, SHALL write burst_i into line bits [64*cnt+63 : 64*cnt] and increment cnt.
REQ-009 In RD, resp_i with cnt=3 SHALL capture the last beat and go to RD_DONE; resp_i beats need not be consecutive, and stall cycles with resp_i=0 hold state.
REQ-010 RD_DONE SHALL last exactly one cycle with resp_o=1, read_o=0 and line_o holding the full assembled line, then return to IDLE.
REQ-011 line_o SHALL hold its value until the next read overwrites it beat by beat; line_o is valid only when resp_o=1.
REQ-012 In WR, SHALL drive write_o=1 and burst_o = latched line [64*cnt+63 : 64*cnt], and SHALL increment cnt on each resp_i=1.
REQ-013 In WR, resp_i with cnt=3 SHALL go to WR_DONE, which lasts exactly one cycle with resp_o=1, then returns to IDLE.
REQ-014 Outside RD, read_o SHALL be 0; outside WR, write_o SHALL be 0; read_o and write_o SHALL never be 1 together.
REQ-015 In IDLE, RD_DONE and WR_DONE, resp_i SHALL be ignored; line_i changing after the latch SHALL not affect burst_o.
REQ-016 Total latency SHALL be 1 (accept) + 4 beat cycles (minimum) + 1 (done), i.e. resp_o at cycle 6 after the request with no memory stalls.
REQ-017 A request still asserted in the IDLE cycle after a done state SHALL start a new transaction, so requesters must drop the request upon seeing resp_o.
REQ-018 When cnt reaches 3 and advances, it SHALL wrap to 0 and SHALL be cleared again on every IDLE accept.

Reset
REQ-019 rst=1 SHALL immediately force state to IDLE, cnt to 0, read_o, write_o and resp_o to 0, line_o to 0, and address_o and burst_o to 0.
REQ-020 Reset mid-RD or mid-WR SHALL abort the transaction with no resp_o, and after deassertion the block SHALL accept a fresh request in IDLE.

Verification
REQ-021 Read: address_i=0x0000_1234, read_i=1, resp_i=1 for 4 cycles with burst_i=0xA0..0,0xA1..1,0xA2..2,0xA3..3 -> address_o=0x0000_1220, line_o={A3..3,A2..2,A1..1,A0..0} with resp_o=1 for 1 cycle at cycle 6.
REQ-022 Write: line_i=256'h{D3,D2,D1,D0} 64-bit words, write_i=1 -> burst_o=D0,D1,D2,D3 on successive resp_i cycles, then resp_o for 1 cycle, with write_o low in that cycle.
REQ-023 Stalled read: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, resp_o one cycle after the 7th pattern cycle.
REQ-024 Simultaneous read_i=1 and write_i=1 in IDLE -> write_o=1, read_o=0, and D0 is presented first.
REQ-025 rst pulsed after 2 read beats -> read_o=0 immediately with no resp_o; a new read afterwards completes with the correct line.
REQ-026 Back-to-back requests: read_i held for 1 cycle after resp_o -> a second read starts; after a read, line_o stays stable while write_i transactions run.
